// File: rtl/mem_access_unit_if.sv
// Pipeline request/response and word-memory bus for mem_access_unit.
// The unit takes the slave side; the pipeline/memory environment the master.
interface mem_access_unit_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_op;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          misalign_err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, misalign_err,
        output mem_addr, mem_wdata, mem_we
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, misalign_err,
        input  mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: sub-word extension, SB/SH read-modify-write.
// Define MISALIGN_TRAP_EN to trap misaligned LH/LHU/SH/LW/SW instead of aligning.
module mem_access_unit #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_access_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR} state_t;

    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0010;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1010;

    state_t        state_q, state_d;
    logic [3:0]    op_q, op_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] merge_q, merge_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;
    logic          err_q, err_d;

    logic          we;
    logic          mis;
    logic          is_load;
    logic [DW-1:0] ld_val;
    logic [DW-1:0] merged;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;

`ifdef MISALIGN_TRAP_EN
    assign mis = (((op_q == OP_LH) || (op_q == OP_LHU) || (op_q == OP_SH))
                  && addr_q[0])
              || (((op_q == OP_LW) || (op_q == OP_SW))
                  && (addr_q[1:0] != 2'b00));
`else
    assign mis = 1'b0;
`endif

    assign is_load = (op_q == OP_LB) || (op_q == OP_LH) || (op_q == OP_LW)
                  || (op_q == OP_LBU) || (op_q == OP_LHU);

    assign byte_v = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign half_v = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        ld_val = '0;
        case (op_q)
            OP_LB:   ld_val = {{(DW-8){byte_v[7]}}, byte_v};
            OP_LBU:  ld_val = {{(DW-8){1'b0}}, byte_v};
            OP_LH:   ld_val = {{(DW-16){half_v[15]}}, half_v};
            OP_LHU:  ld_val = {{(DW-16){1'b0}}, half_v};
            OP_LW:   ld_val = bus.mem_rdata;
            default: ld_val = '0;
        endcase
    end

    // Only the addressed lane(s) change; every other byte of the old word survives.
    always_comb begin
        merged = merge_q;
        if (op_q == OP_SH) begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end else begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        merge_d   = merge_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        err_d     = 1'b0;
        we        = 1'b0;
        bus.mem_wdata = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    op_d    = bus.req_op;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                state_d = IDLE;
                if (mis) begin
                    rvalid_d = 1'b1;
                    err_d    = 1'b1;
                end else if ((op_q == OP_SB) || (op_q == OP_SH)) begin
                    merge_d = bus.mem_rdata;
                    state_d = MERGE_WR;
                end else if (op_q == OP_SW) begin
                    we       = 1'b1;
                    rvalid_d = 1'b1;
                end else if (is_load) begin
                    rdata_d  = ld_val;
                    rvalid_d = 1'b1;
                end else begin
                    rdata_d  = '0;
                    rvalid_d = 1'b1;
                end
            end
            MERGE_WR: begin
                we            = 1'b1;
                bus.mem_wdata = merged;
                rvalid_d      = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            merge_q  <= merge_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    // Reset must block a write even when it lands mid-transaction.
    assign bus.mem_we       = we & rst_n;
    assign bus.req_ready    = (state_q == IDLE);
    assign bus.mem_addr     = (state_q == IDLE) ? '0 : {2'b00, addr_q[AW-1:2]};
    assign bus.resp_valid   = rvalid_q;
    assign bus.resp_rdata   = rdata_q;
    assign bus.misalign_err = err_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed vector bench for mem_access_unit with a 16-word memory model.
// Vectors are issued back-to-back: each request is offered in the previous resp cycle.
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_access_unit_if #(.AW(32), .DW(32)) bus ();

    mem_access_unit #(.AW(32), .DW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem [16];
    logic        pk_en;
    logic [3:0]  pk_a;
    logic [31:0] pk_d;

    always @(posedge clk) begin
        if (pk_en) mem[pk_a] <= pk_d;
        else if (bus.mem_we) mem[bus.mem_addr[3:0]] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = mem[bus.mem_addr[3:0]];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic xact(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat, output int wes,
                        output logic [31:0] ma, output logic err,
                        output int rdy_busy, output logic rdy_issue);
        rdy_issue = bus.req_ready;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0; wes = 0; rdy_busy = 0; ma = '1; rd = '0; err = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.mem_we) wes++;
            if (i == 1) ma = bus.mem_addr;
            if (bus.resp_valid) begin
                lat = i;
                rd  = bus.resp_rdata;
                err = bus.misalign_err;
                break;
            end
            if (bus.req_ready) rdy_busy++;
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        int          lat;
        int          wes;
    } vec_t;

    vec_t tv [16];

    logic [31:0] rd, ma, saved;
    int          lat, wes, rb;
    logic        err, ri;
    int          stray;

    initial begin
        tv[0]  = '{4'b0010, 32'h0C, 32'h0,        32'h8899AABB, 2, 0};
        tv[1]  = '{4'b0000, 32'h04, 32'h0,        32'hFFFFFF80, 2, 0};
        tv[2]  = '{4'b0100, 32'h04, 32'h0,        32'h00000080, 2, 0};
        tv[3]  = '{4'b0001, 32'h06, 32'h0,        32'h00001234, 2, 0};
        tv[4]  = '{4'b0101, 32'h04, 32'h0,        32'h0000F680, 2, 0};
        tv[5]  = '{4'b0000, 32'h07, 32'h0,        32'h00000012, 2, 0};
        tv[6]  = '{4'b1000, 32'h09, 32'hFFFFFFAB, 32'h00000012, 3, 1};
        tv[7]  = '{4'b0010, 32'h08, 32'h0,        32'h1122AB44, 2, 0};
        tv[8]  = '{4'b1001, 32'h0A, 32'h1234BEEF, 32'h1122AB44, 3, 1};
        tv[9]  = '{4'b0010, 32'h08, 32'h0,        32'hBEEFAB44, 2, 0};
        tv[10] = '{4'b1010, 32'h10, 32'hDEADBEEF, 32'hBEEFAB44, 2, 1};
        tv[11] = '{4'b0010, 32'h10, 32'h0,        32'hDEADBEEF, 2, 0};
        tv[12] = '{4'b0011, 32'h0C, 32'h0,        32'h00000000, 2, 0};
        tv[13] = '{4'b0000, 32'h0F, 32'h0,        32'hFFFFFF88, 2, 0};
        tv[14] = '{4'b0101, 32'h0E, 32'h0,        32'h00008899, 2, 0};
        tv[15] = '{4'b0001, 32'h0A, 32'h0,        32'hFFFFBEEF, 2, 0};

        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        pk_en = 1'b0; pk_a = '0; pk_d = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            pk_en = 1'b1;
            pk_a  = 4'(i);
            case (i)
                1:       pk_d = 32'h1234F680;
                2:       pk_d = 32'h11223344;
                3:       pk_d = 32'h8899AABB;
                default: pk_d = 32'h0;
            endcase
        end
        @(negedge clk);
        pk_en = 1'b0;

        chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
        chk("rst_misalign", 32'(bus.misalign_err), 32'h0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'h1);
        chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 16; v++) begin
            xact(tv[v].op, tv[v].addr, tv[v].wd, rd, lat, wes, ma, err, rb, ri);
            chk($sformatf("v%0d_rdata", v), rd, tv[v].rd);
            chk($sformatf("v%0d_latency", v), 32'(lat), 32'(tv[v].lat));
            chk($sformatf("v%0d_we_cycles", v), 32'(wes), 32'(tv[v].wes));
            chk($sformatf("v%0d_mem_addr", v), ma, tv[v].addr >> 2);
            chk($sformatf("v%0d_misalign", v), 32'(err), 32'h0);
            chk($sformatf("v%0d_ready_issue", v), 32'(ri), 32'h1);
            chk($sformatf("v%0d_ready_busy", v), 32'(rb), 32'h0);
            if (v == 6) chk("sb_mem2", mem[2], 32'h1122AB44);
            if (v == 8) chk("sh_mem2", mem[2], 32'hBEEFAB44);
            if (v == 10) chk("sw_mem4", mem[4], 32'hDEADBEEF);
        end

        // Reset dropped into the MERGE_WR cycle of an SB
        @(negedge clk);
        saved = mem[2];
        bus.req_valid = 1'b1;
        bus.req_op    = 4'b1000;
        bus.req_addr  = 32'h09;
        bus.req_wdata = 32'h00000077;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk("rstmid_we_gated", 32'(bus.mem_we), 32'h0);
        @(negedge clk);
        chk("rstmid_mem2", mem[2], saved);
        chk("rstmid_ready", 32'(bus.req_ready), 32'h1);
        chk("rstmid_mem_addr", bus.mem_addr, 32'h0);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.resp_valid || bus.mem_we || !bus.req_ready) stray++;
        end
        chk("rstmid_quiet", 32'(stray), 32'h0);
        chk("rstmid_mem2_after", mem[2], saved);
        xact(4'b0010, 32'h08, 32'h0, rd, lat, wes, ma, err, rb, ri);
        chk("post_rst_lw", rd, 32'hBEEFAB44);
        chk("post_rst_lat", 32'(lat), 32'h2);

        xact(4'b0010, 32'h0E, 32'h0, rd, lat, wes, ma, err, rb, ri);
        chk("lw0e_latency", 32'(lat), 32'h2);
        chk("lw0e_we", 32'(wes), 32'h0);
`ifdef MISALIGN_TRAP_EN
        chk("lw0e_err", 32'(err), 32'h1);
        chk("lw0e_rdata_held", rd, 32'hBEEFAB44);
`else
        chk("lw0e_err", 32'(err), 32'h0);
        chk("lw0e_rdata", rd, 32'h8899AABB);
`endif
        @(negedge clk);
        chk("pulse_single", 32'(bus.resp_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
